// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for fft_top: ADC sample capture, FFT launch, result stream-out.
// Optional drop counter output oDROP_CNT, enabled by defining FFT_FRAME_DROP_CNT_EN.
//
// Ports:
//   iCLK, iRESET           clock, synchronous active-high reset
//   iARM                   request to capture the next frame (IDLE only)
//   iSAMPLE/_VALID         ADC sample stream
//   oDATA, oADDR_WR_k      bank write data/address to fft_top
//   oWE_k                  bank write enables
//   oSTART, iRDY           FFT launch pulse and ready handshake
//   oADDR_RD_k             bank read address (same value to all banks)
//   iDATA_RE_k             bank read data, RD_LAT cycles after the address
//   oRES/_VALID/_IDX       natural-order result stream
//   oBUSY, oDONE, oDROP    status: busy level, frame done, sample dropped
//   oDROP_CNT              saturating drop count (optional)
module fft_frame_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9,
    parameter int RD_LAT = 2
) (
    input  logic              iCLK,
    input  logic              iRESET,
    input  logic              iARM,
    input  logic [DATA_W-1:0] iSAMPLE,
    input  logic              iSAMPLE_VALID,
    output logic [DATA_W-1:0] oDATA,
    output logic [ADDR_W-1:0] oADDR_WR_0,
    output logic [ADDR_W-1:0] oADDR_WR_1,
    output logic [ADDR_W-1:0] oADDR_WR_2,
    output logic [ADDR_W-1:0] oADDR_WR_3,
    output logic              oWE_0,
    output logic              oWE_1,
    output logic              oWE_2,
    output logic              oWE_3,
    output logic              oSTART,
    input  logic              iRDY,
    output logic [ADDR_W-1:0] oADDR_RD_0,
    output logic [ADDR_W-1:0] oADDR_RD_1,
    output logic [ADDR_W-1:0] oADDR_RD_2,
    output logic [ADDR_W-1:0] oADDR_RD_3,
    input  logic [DATA_W-1:0] iDATA_RE_0,
    input  logic [DATA_W-1:0] iDATA_RE_1,
    input  logic [DATA_W-1:0] iDATA_RE_2,
    input  logic [DATA_W-1:0] iDATA_RE_3,
    output logic [DATA_W-1:0] oRES,
    output logic              oRES_VALID,
    output logic [ADDR_W+1:0] oRES_IDX,
    output logic              oBUSY,
    output logic              oDONE,
    output logic              oDROP
`ifdef FFT_FRAME_DROP_CNT_EN
    ,
    output logic [15:0]       oDROP_CNT
`endif
);

    localparam int IDX_W = ADDR_W + 2;
    localparam int DRN_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_LAUNCH,
        S_WAIT,
        S_READ,
        S_DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0]              n_q, n_d;
    logic [IDX_W-1:0]              r_q, r_d;
    logic [DRN_W-1:0]              drain_q, drain_d;
    logic [DATA_W-1:0]             data_q, data_d;
    logic [3:0][ADDR_W-1:0]        awr_q, awr_d;
    logic [3:0]                    we_q, we_d;
    logic                          start_q, start_d;
    logic                          drop_q, drop_d;
    logic                          busy_q, busy_d;
    logic [RD_LAT-1:0]             dv_q, dv_d;
    logic [RD_LAT-1:0][IDX_W-1:0]  di_q, di_d;

    logic       accept;
    logic       arm_acc;
    logic       last_n;
    logic       last_r;
    logic       drain_end;
    logic       rd_issue;
    logic       done;
    logic [1:0] wr_bank;
    logic [1:0] res_bank;

    assign accept    = (state_q == S_CAPTURE) && iSAMPLE_VALID;
    assign arm_acc   = (state_q == S_IDLE) && iARM;
    assign last_n    = (n_q == '1);
    assign last_r    = (r_q == '1);
    assign drain_end = (drain_q == DRN_W'(RD_LAT - 1));
    assign wr_bank   = n_q[IDX_W-1:ADDR_W];
    assign res_bank  = di_q[RD_LAT-1][IDX_W-1:ADDR_W];

    // State register
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (iARM) state_d = S_CAPTURE;
            S_CAPTURE: if (accept && last_n) state_d = S_LAUNCH;
            S_LAUNCH:  state_d = S_WAIT;
            // start_q is high only in the first WAIT cycle; a ready
            // left over from the previous transform is ignored there.
            S_WAIT:    if (!start_q && iRDY) state_d = S_READ;
            S_READ:    if (last_r) state_d = S_DRAIN;
            S_DRAIN:   if (drain_end) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        start_d  = (state_q == S_LAUNCH);
        drop_d   = iSAMPLE_VALID && (state_q != S_CAPTURE);
        busy_d   = (state_d != S_IDLE);
        rd_issue = (state_q == S_READ);
        done     = (state_q == S_DRAIN) && drain_end;
        we_d     = '0;
        if (accept) we_d[wr_bank] = 1'b1;
    end

    // Counters, write path and read-tag delay line
    always_comb begin
        n_d = n_q;
        if (arm_acc) begin
            n_d = '0;
        end else if (accept) begin
            n_d = n_q + IDX_W'(1);
        end

        r_d = r_q;
        if ((state_q == S_WAIT) && (state_d == S_READ)) begin
            r_d = '0;
        end else if (rd_issue) begin
            r_d = r_q + IDX_W'(1);
        end

        drain_d = '0;
        if (state_q == S_DRAIN) drain_d = drain_q + DRN_W'(1);

        data_d = data_q;
        awr_d  = awr_q;
        if (accept) begin
            data_d           = iSAMPLE;
            awr_d[wr_bank]   = n_q[ADDR_W-1:0];
        end

        // Tag each issued index so it lines up with the RAM output
        dv_d    = '0;
        di_d    = '0;
        dv_d[0] = rd_issue;
        di_d[0] = r_q;
        for (int i = 1; i < RD_LAT; i++) begin
            dv_d[i] = dv_q[i-1];
            di_d[i] = di_q[i-1];
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            n_q     <= '0;
            r_q     <= '0;
            drain_q <= '0;
            data_q  <= '0;
            awr_q   <= '0;
            we_q    <= '0;
            start_q <= 1'b0;
            drop_q  <= 1'b0;
            busy_q  <= 1'b0;
            dv_q    <= '0;
            di_q    <= '0;
        end else begin
            n_q     <= n_d;
            r_q     <= r_d;
            drain_q <= drain_d;
            data_q  <= data_d;
            awr_q   <= awr_d;
            we_q    <= we_d;
            start_q <= start_d;
            drop_q  <= drop_d;
            busy_q  <= busy_d;
            dv_q    <= dv_d;
            di_q    <= di_d;
        end
    end

    // Result word comes straight from the bank that holds the tagged index
    always_comb begin
        oRES = '0;
        if (dv_q[RD_LAT-1]) begin
            unique case (res_bank)
                2'd0: oRES = iDATA_RE_0;
                2'd1: oRES = iDATA_RE_1;
                2'd2: oRES = iDATA_RE_2;
                2'd3: oRES = iDATA_RE_3;
            endcase
        end
    end

    assign oDATA      = data_q;
    assign oADDR_WR_0 = awr_q[0];
    assign oADDR_WR_1 = awr_q[1];
    assign oADDR_WR_2 = awr_q[2];
    assign oADDR_WR_3 = awr_q[3];
    assign oWE_0      = we_q[0];
    assign oWE_1      = we_q[1];
    assign oWE_2      = we_q[2];
    assign oWE_3      = we_q[3];
    assign oSTART     = start_q;
    assign oADDR_RD_0 = r_q[ADDR_W-1:0];
    assign oADDR_RD_1 = r_q[ADDR_W-1:0];
    assign oADDR_RD_2 = r_q[ADDR_W-1:0];
    assign oADDR_RD_3 = r_q[ADDR_W-1:0];
    assign oRES_VALID = dv_q[RD_LAT-1];
    assign oRES_IDX   = di_q[RD_LAT-1];
    assign oBUSY      = busy_q;
    assign oDONE      = done;
    assign oDROP      = drop_q;

`ifdef FFT_FRAME_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Arm clears first so a drop in the arming cycle still counts
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (arm_acc) drop_cnt_d = '0;
        if (drop_d && (drop_cnt_d != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_d + 16'd1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign oDROP_CNT = drop_cnt_q;
`endif

endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
Frame sequencer in front of fft_top. Captures a 2048-point ADC sample stream into the four 512-word input banks, pulses the FFT start and waits for ready. It then streams the 2048 real results back out in natural index order. Replaces the manual bank-load and readout done by the bench, for use in the synthesizable top.

Parameters:
DATA_W, 16, sample and result word width (signed)
ADDR_W, 9, per-bank address width; frame length = 4 * 2^ADDR_W = 2048
RD_LAT, 2, cycles from oADDR_RD_k change to valid iDATA_RE_k (registered altsyncram output)

Ports:
iCLK  in  1  clock
iRESET  in  1  synchronous reset, active-high
iARM  in  1  one-cycle request to capture the next frame
iSAMPLE  in  DATA_W  ADC sample
iSAMPLE_VALID  in  1  sample qualifier
oDATA  out  DATA_W  write data to fft_top iDATA
oADDR_WR_0..3  out  ADDR_W each  write addresses to fft_top
oWE_0..3  out  1 each  bank write enables
oSTART  out  1  FFT launch pulse to fft_top iSTART
iRDY  in  1  fft_top oRDY
oADDR_RD_0..3  out  ADDR_W each  read addresses to fft_top
iDATA_RE_0..3  in  DATA_W each  result words from fft_top
oRES  out  DATA_W  result stream data
oRES_VALID  out  1  result qualifier
oRES_IDX  out  11  result index 0..2047
oBUSY  out  1  high whenever state != IDLE
oDONE  out  1  one-cycle pulse, frame fully streamed
oDROP  out  1  one-cycle pulse, sample discarded

Behaviour:
- Reset: state IDLE, sample/read counters 0, pipeline flushed. All outputs 0: oWE_*, oSTART, oRES_VALID, oDONE, oDROP, oBUSY, and all data/address buses.
- States: IDLE, CAPTURE, LAUNCH, WAIT, READ, DRAIN.
- IDLE: iARM=1 -> CAPTURE next cycle, sample counter n=0. A valid sample in the same cycle as iARM is dropped.
- CAPTURE, sample accepted at cycle c (iSAMPLE_VALID=1):
  - at c+1: oDATA=sample, bank b=n[10:9], oADDR_WR_b=n[8:0], oWE_b=1 for one cycle.
  - Other WE stay 0. Write addresses hold their last value. n increments.
  - Accepting n=2047 -> LAUNCH.
- Gaps in iSAMPLE_VALID just stall capture. There is no timeout.
- LAUNCH: oSTART=1 for exactly one cycle, in the cycle directly after the last oWE pulse. Then WAIT.
- WAIT:
  - iRDY is ignored in the first cycle after oSTART, so a stale ready is not seen.
  - After that, iRDY=1 -> READ, read counter r=0.
- READ: each cycle, drive all oADDR_RD_k = r[8:0] and push r into a RD_LAT-deep delay line; r increments. After r=2047 is issued -> DRAIN.
- DRAIN: holds for RD_LAT cycles, then IDLE with oDONE=1 for one cycle.
- Result path: RD_LAT cycles after index r is issued, oRES = iDATA_RE_{r[10:9]}, oRES_IDX=r, oRES_VALID=1.
  - 2048 consecutive valid cycles with no bubbles.
  - No backpressure; the consumer must accept every cycle.
- oDROP pulses one cycle after any iSAMPLE_VALID outside CAPTURE (IDLE, LAUNCH, WAIT, READ, DRAIN).
- iARM outside IDLE is ignored, with no error.
- oBUSY is registered and rises the cycle after iARM is accepted.
- Reset mid-operation (any state): IDLE next cycle and all pulses cleared. Pending delay-line entries are discarded, so no oRES_VALID is issued after reset. Partially written banks are left as is.

Optional Feature:
FFT_FRAME_DROP_CNT_EN:
- Defined: adds output oDROP_CNT [15:0], which counts oDROP pulses.
  - Saturates at 16'hFFFF.
  - Cleared by iRESET and on every accepted iARM.
- Not defined: port and counter absent; oDROP pulse unchanged.

Test Plan:
- Reset 3 cycles, then iARM with 2048 contiguous samples of value 16'd2 -> 512 oWE pulses per bank, bank0 addr 0..511 first, then bank1..3. oSTART=1 exactly one cycle after the last oWE_3 (addr 511). oBUSY=1 throughout.
- iRDY held 1 before and during oSTART -> no READ until the second cycle after oSTART. With iRDY model delay 100 cycles after START, the first oRES_VALID arrives at READ entry + RD_LAT.
- Bank model returning data = {bank, addr} -> oRES_IDX runs 0..2047 contiguous and oRES matches the index mapping. oDONE pulses exactly RD_LAT cycles after the last read issued.
- Samples during WAIT (5 valids) plus a second iARM during READ -> 5 oDROP pulses, no extra oWE, state unaffected. With FFT_FRAME_DROP_CNT_EN, oDROP_CNT=5, and the next iARM clears it to 0.
- Samples with 1-in-3 valid duty -> capture completes after exactly 2048 accepted samples. Addresses have no gaps.
- iRESET asserted at READ r=1000 -> next cycle oBUSY=0 and oRES_VALID=0 for all later cycles. Re-arming gives a correct full frame starting at index 0.
